spi_mult_periph: RTL

- Parametrised SPI-slave multiplier peripheral; successor to the fixed 4-bit SPI multiplier.
- Each SPI frame shifts in two W-bit unsigned operands on mosi (A then B).
- Full-duplex: during the same frame, miso shifts out the 2W-bit product of the previous completed frame.
- All SPI pins are synchronised into clk; the multiply is sequential shift-add; there is a frame-abort error path.

---
 rtl/spi_mult_periph_if.sv | 25 ++
 rtl/spi_mult_periph.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mult_periph_if.sv
// SPI pin bundle plus the peripheral's readback/status outputs.
// The master side drives sclk/cs/mosi; the slave (the peripheral) drives
// the serial return path, the tristate enable and the status pulses.
interface spi_mult_periph_if #(
    parameter int W = 4
);
    logic           sclk;
    logic           cs;
    logic           mosi;
    logic           miso;
    logic           miso_oe;
    logic [2*W-1:0] product;
    logic           done;
    logic           frame_err;

    modport master (
        output sclk, cs, mosi,
        input  miso, miso_oe, product, done, frame_err
    );

    modport slave (
        input  sclk, cs, mosi,
        output miso, miso_oe, product, done, frame_err
    );
endinterface

// File: rtl/spi_mult_periph.sv
// SPI-slave (mode 0) multiplier peripheral.
// A frame of 2W bits carries operand A then operand B, MSB first. While the
// frame shifts in, the product of the previous completed frame shifts out on
// miso. SPI pins are synchronised into clk and edge-detected; the multiply is
// a W-cycle unsigned shift-add. Short frames and chip-selects that fall while
// a multiply is still pending are reported on frame_err.
module spi_mult_periph #(
    parameter int W    = 4,
    parameter int SYNC = 2
) (
    input  logic             clk,
    input  logic             reset,
    spi_mult_periph_if.slave bus
);
    localparam int PW = 2 * W;
    localparam int CW = $clog2(PW + 1);
    localparam int IW = $clog2(W + 1);
    localparam logic [CW-1:0] FRAME_BITS = CW'(PW);
    localparam logic [IW-1:0] ITERS      = IW'(W);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SHIFT   = 2'd1,
        S_MULT    = 2'd2,
        S_WAIT_CS = 2'd3
    } state_t;

    // Synchroniser chains and delayed copies of the last stage
    logic [SYNC-1:0] r_sclk_sync;
    logic [SYNC-1:0] r_cs_sync;
    logic [SYNC-1:0] r_mosi_sync;
    logic            r_sclk_d;
    logic            r_cs_d;

    // Synchronised pin levels and their edges
    logic w_sclk;
    logic w_cs;
    logic w_mosi;
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_cs_rise;
    logic w_cs_fall;

    // Sequencer and datapath state
    state_t          r_state;
    logic [PW-1:0]   r_rx;
    logic [PW-1:0]   r_tx;
    logic [CW-1:0]   r_cnt;
    logic [PW-1:0]   r_a;
    logic [W-1:0]    r_b;
    logic [PW-1:0]   r_acc;
    logic [IW-1:0]   r_iter;
    logic [PW-1:0]   r_product;
    logic            r_done;
    logic            r_frame_err;
    logic            r_miso;
    logic            r_miso_oe;

    // Next-state values
    state_t          w_state_nxt;
    logic [PW-1:0]   w_rx_nxt;
    logic [PW-1:0]   w_tx_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [PW-1:0]   w_a_nxt;
    logic [W-1:0]    w_b_nxt;
    logic [PW-1:0]   w_acc_nxt;
    logic [IW-1:0]   w_iter_nxt;
    logic [PW-1:0]   w_product_nxt;
    logic            w_done_nxt;
    logic            w_err_nxt;
    logic            w_miso_nxt;
    logic            w_miso_oe_nxt;
    logic [CW-1:0]   w_cnt_inc;
    logic            w_last_rise;

    // Bring sclk, cs and mosi into the clk domain; cs idles high
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC-2:0], bus.sclk};
            r_cs_sync   <= {r_cs_sync[SYNC-2:0], bus.cs};
            r_mosi_sync <= {r_mosi_sync[SYNC-2:0], bus.mosi};
            r_sclk_d    <= r_sclk_sync[SYNC-1];
            r_cs_d      <= r_cs_sync[SYNC-1];
        end
    end

    assign w_sclk      = r_sclk_sync[SYNC-1];
    assign w_cs        = r_cs_sync[SYNC-1];
    assign w_mosi      = r_mosi_sync[SYNC-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk & r_sclk_d;
    assign w_cs_rise   = w_cs & ~r_cs_d;
    assign w_cs_fall   = ~w_cs & r_cs_d;

    // Frame sequencing, shift-add multiply and registered-output decode
    always_comb begin
        w_state_nxt   = r_state;
        w_rx_nxt      = r_rx;
        w_tx_nxt      = r_tx;
        w_cnt_nxt     = r_cnt;
        w_a_nxt       = r_a;
        w_b_nxt       = r_b;
        w_acc_nxt     = r_acc;
        w_iter_nxt    = r_iter;
        w_product_nxt = r_product;
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b0;
        w_cnt_inc     = r_cnt + CW'(1);
        // The 2W-th rise wins over a cs rise seen in the same cycle
        w_last_rise   = w_sclk_rise && (w_cnt_inc == FRAME_BITS);

        case (r_state)
            S_IDLE: begin
                if (w_cs_fall) begin
                    w_tx_nxt    = r_product;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_SHIFT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end

            S_SHIFT: begin
                if (r_cnt == FRAME_BITS) begin
                    // Full frame received: latch operands and start the multiply
                    w_a_nxt     = {{W{1'b0}}, r_rx[PW-1:W]};
                    w_b_nxt     = r_rx[W-1:0];
                    w_acc_nxt   = '0;
                    w_iter_nxt  = '0;
                    w_state_nxt = S_MULT;
                end else begin
                    if (w_sclk_rise) begin
                        w_rx_nxt  = {r_rx[PW-2:0], w_mosi};
                        w_cnt_nxt = w_cnt_inc;
                    end else begin
                        w_cnt_nxt = r_cnt;
                    end
                    if (w_sclk_fall) begin
                        w_tx_nxt = {r_tx[PW-2:0], 1'b0};
                    end else begin
                        w_tx_nxt = r_tx;
                    end
                    if (w_cs_rise && !w_last_rise) begin
                        // Short frame: drop what was received, keep old product
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_SHIFT;
                    end
                end
            end

            S_MULT: begin
                if (w_cs_fall) begin
                    w_err_nxt = 1'b1;
                end else begin
                    w_err_nxt = 1'b0;
                end
                if (r_iter == ITERS) begin
                    w_product_nxt = r_acc;
                    w_done_nxt    = 1'b1;
                    w_state_nxt   = S_WAIT_CS;
                end else begin
                    if (r_b[0]) begin
                        w_acc_nxt = r_acc + r_a;
                    end else begin
                        w_acc_nxt = r_acc;
                    end
                    w_a_nxt    = {r_a[PW-2:0], 1'b0};
                    w_b_nxt    = {1'b0, r_b[W-1:1]};
                    w_iter_nxt = r_iter + IW'(1);
                end
            end

            S_WAIT_CS: begin
                if (w_cs_fall) begin
                    w_err_nxt = 1'b1;
                end else begin
                    w_err_nxt = 1'b0;
                end
                if (w_cs) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_WAIT_CS;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // miso is only driven while a frame is actively shifting
        w_miso_oe_nxt = (w_state_nxt == S_SHIFT);
        if (w_miso_oe_nxt) begin
            w_miso_nxt = w_tx_nxt[PW-1];
        end else begin
            w_miso_nxt = 1'b0;
        end
    end

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rx        <= '0;
            r_tx        <= '0;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_iter      <= '0;
            r_product   <= '0;
            r_done      <= 1'b0;
            r_frame_err <= 1'b0;
            r_miso      <= 1'b0;
            r_miso_oe   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rx        <= w_rx_nxt;
            r_tx        <= w_tx_nxt;
            r_cnt       <= w_cnt_nxt;
            r_a         <= w_a_nxt;
            r_b         <= w_b_nxt;
            r_acc       <= w_acc_nxt;
            r_iter      <= w_iter_nxt;
            r_product   <= w_product_nxt;
            r_done      <= w_done_nxt;
            r_frame_err <= w_err_nxt;
            r_miso      <= w_miso_nxt;
            r_miso_oe   <= w_miso_oe_nxt;
        end
    end

    assign bus.miso      = r_miso;
    assign bus.miso_oe   = r_miso_oe;
    assign bus.product   = r_product;
    assign bus.done      = r_done;
    assign bus.frame_err = r_frame_err;

endmodule
